ps2_mouse_ctrl: RTL and testbench
=================================

Name: ps2_mouse_ctrl

Overview:
Controller between the PS/2 byte receiver/transmitter and the mouse signal mapper.
- After reset, runs the mouse initialisation handshake: reset, self-test, then enable data reporting.
- Then assembles the 3-byte stream packets, resynchronising on bit 3 of byte 1.
- Presents each complete packet on o_signal1..3 with a one-cycle o_packet_valid strobe for the mapper.

Parameters:
RESP_TIMEOUT, 50_000_000, max cycles to wait for any init response byte (500 ms @ 100 MHz)
PKT_GAP, 200_000, max idle cycles between bytes of one packet before the assembler discards the partial packet
MAX_RETRY, 3, init attempts before declaring failure

Ports:
i_clk  input  1  system clock
i_reset  input  1  asynchronous, active-low reset
i_rx_data  input  8  validated byte from the PS/2 receiver
i_rx_valid  input  1  one-cycle strobe; i_rx_data is valid
i_tx_ready  input  1  PS/2 transmitter idle, can accept a command
o_tx_data  output  8  command byte to the transmitter
o_tx_start  output  1  one-cycle strobe; transmitter launches o_tx_data
o_signal1  output  8  packet byte 1 (buttons/sign/overflow)
o_signal2  output  8  packet byte 2 (X)
o_signal3  output  8  packet byte 3 (Y)
o_packet_valid  output  1  one-cycle strobe; o_signal1..3 just updated
o_streaming  output  1  init complete, packets flowing
o_init_error  output  1  sticky; init failed MAX_RETRY times

Behaviour:
Reset (i_reset=0, async):
- All outputs 0; state TX_RST; retry count 0; byte index 0; timers 0.

States:
- TX_RST: wait for i_tx_ready=1, then pulse o_tx_start for 1 cycle with o_tx_data=0xFF -> W_ACK1.
- W_ACK1: expect 0xFA -> W_BAT.
- W_BAT: expect 0xAA -> W_ID.
- W_ID: expect 0x00 -> TX_EN.
- TX_EN: wait for i_tx_ready=1, then pulse o_tx_start with o_tx_data=0xF4 -> W_ACK2.
- W_ACK2: expect 0xFA -> STREAM; o_streaming=1 from the next cycle.
- FAIL: o_init_error=1; all rx ignored; exits only on reset.
- o_tx_data holds its value after the strobe.

Wait-state rules (W_*):
- Response timer clears on state entry and increments every cycle.
- Wrong byte, or timer reaching RESP_TIMEOUT -> retry: increment retry count, go to TX_RST.
- If the increment makes retry count == MAX_RETRY, go to FAIL instead.
- A byte and timeout in the same cycle: the byte is evaluated; timeout is ignored.
- The TX states have no timeout; they wait indefinitely for i_tx_ready.

STREAM:
- Byte index idx takes values 0..2.
- idx=0: byte accepted only if i_rx_data[3]=1, stored as byte1, idx<=1; otherwise discarded, idx stays 0.
- idx=1: store byte2, idx<=2.
- idx=2: on the next edge, o_signal1<=byte1, o_signal2<=byte2, o_signal3<=i_rx_data, o_packet_valid=1 for exactly 1 cycle, idx<=0.
- Latency: 1 cycle from the byte-3 i_rx_valid edge.
- o_signal1..3 hold the last packet between strobes. They never change on a partial or discarded packet.
- Gap timer: clears on every accepted byte and increments while idx!=0. Reaching PKT_GAP sets idx<=0 and drops stored bytes; no strobe.
- Gap expiry and i_rx_valid in the same cycle: the byte wins (accepted at the current idx, timer clears).
- i_tx_ready is ignored; o_tx_start stays 0.
- Back-to-back i_rx_valid on consecutive cycles must be handled with no loss.

Reset mid-operation:
- Immediate return to the reset values; the init sequence restarts from TX_RST after deassertion.

Test Plan:
- Init happy path (RESP_TIMEOUT=1000): i_tx_ready=1, reply FA, AA, 00 after 0xFF strobe, FA after 0xF4 strobe -> exactly two o_tx_start pulses (0xFF then 0xF4), o_streaming=1 one cycle after final FA, o_init_error=0.
- Packet assembly in STREAM: bytes 0x09, 0x10, 0xF0 (including back-to-back strobes) -> one cycle after the 0xF0 strobe: o_signal1=0x09, o_signal2=0x10, o_signal3=0xF0, o_packet_valid high for exactly 1 cycle.
- Resync: bytes 0x00, 0x28, 0x05, 0xFB -> 0x00 discarded; packet {0x28, 0x05, 0xFB} presented; exactly one strobe.
- Gap timeout (PKT_GAP=100): 0x09, 0x10, then idle 100 cycles, then 0x0A, 0x01, 0x02 -> no strobe for the first pair; strobe with {0x0A, 0x01, 0x02}. Repeat with a byte arriving on the expiry cycle -> the byte is accepted as the next packet byte.
- Init failure (MAX_RETRY=3): answer 0xFE to every 0xFF -> 3 separate 0xFF strobes, then o_init_error=1, o_streaming=0. A separate run with no reply: retry every RESP_TIMEOUT cycles, same outcome.
- Async reset: assert i_reset=0 between packet bytes 2 and 3 -> all outputs 0 without a clock edge; after release a 0xFF strobe issues when i_tx_ready=1.

Source files
------------

// File: rtl/ps2_mouse_ctrl.sv
// -----------------------------------------------------------------------------
// ps2_mouse_ctrl
//
// Sits between the PS/2 byte receiver/transmitter and the mouse signal mapper.
// After reset it runs the mouse initialisation handshake:
//   send 0xFF (reset) -> expect 0xFA, 0xAA, 0x00 -> send 0xF4 (enable
//   reporting) -> expect 0xFA.
// Then it assembles the 3-byte stream packets, resynchronising on bit 3 of
// byte 1. It presents each complete packet on o_signal1..3 with a one-cycle
// o_packet_valid strobe.
//
// Parameters
//   RESP_TIMEOUT : max cycles spent waiting for any init response byte
//   PKT_GAP      : max idle cycles between bytes of one packet
//   MAX_RETRY    : init attempts before giving up (o_init_error)
//
// Ports
//   i_clk          system clock
//   i_reset        asynchronous, active-low reset
//   i_rx_data      byte from the PS/2 receiver, qualified by i_rx_valid
//   i_rx_valid     one-cycle strobe; i_rx_data is valid
//   i_tx_ready     PS/2 transmitter idle, can accept a command
//   o_tx_data      command byte to the transmitter (held after the strobe)
//   o_tx_start     one-cycle strobe; transmitter launches o_tx_data
//   o_signal1..3   last complete packet (buttons/sign/ovf, X, Y)
//   o_packet_valid one-cycle strobe; o_signal1..3 just updated
//   o_streaming    init complete, packets flowing
//   o_init_error   sticky; init failed MAX_RETRY times
// -----------------------------------------------------------------------------
module ps2_mouse_ctrl #(
    parameter int RESP_TIMEOUT = 50_000_000,
    parameter int PKT_GAP      = 200_000,
    parameter int MAX_RETRY    = 3
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic [7:0] i_rx_data,
    input  logic       i_rx_valid,
    input  logic       i_tx_ready,
    output logic [7:0] o_tx_data,
    output logic       o_tx_start,
    output logic [7:0] o_signal1,
    output logic [7:0] o_signal2,
    output logic [7:0] o_signal3,
    output logic       o_packet_valid,
    output logic       o_streaming,
    output logic       o_init_error
);

    localparam int RESP_W  = $clog2(RESP_TIMEOUT + 1);
    localparam int GAP_W   = $clog2(PKT_GAP + 1);
    localparam int RETRY_W = $clog2(MAX_RETRY + 1);

    // Timers start at 0 on entry, so the last permitted cycle is N-1.
    localparam logic [RESP_W-1:0]  RESP_LAST  = RESP_W'(RESP_TIMEOUT - 1);
    localparam logic [GAP_W-1:0]   GAP_LAST   = GAP_W'(PKT_GAP - 1);
    localparam logic [RETRY_W-1:0] RETRY_LAST = RETRY_W'(MAX_RETRY - 1);

    localparam logic [7:0] CMD_RESET  = 8'hFF;
    localparam logic [7:0] CMD_ENABLE = 8'hF4;
    localparam logic [7:0] RSP_ACK    = 8'hFA;
    localparam logic [7:0] RSP_BAT    = 8'hAA;
    localparam logic [7:0] RSP_ID     = 8'h00;

    typedef enum logic [2:0] {
        S_TX_RST,
        S_W_ACK1,
        S_W_BAT,
        S_W_ID,
        S_TX_EN,
        S_W_ACK2,
        S_STREAM,
        S_FAIL
    } state_t;

    state_t              state_q, state_d;
    logic [RESP_W-1:0]   resp_timer_q, resp_timer_d;
    logic [RETRY_W-1:0]  retry_q, retry_d;
    logic [1:0]          idx_q, idx_d;
    logic [GAP_W-1:0]    gap_q, gap_d;
    logic [7:0]          byte1_q, byte1_d;
    logic [7:0]          byte2_q, byte2_d;

    logic [7:0]          tx_data_d;
    logic                tx_start_d;
    logic [7:0]          sig1_d, sig2_d, sig3_d;
    logic                pkt_valid_d;

    // Expected response and success target for each wait state.
    logic [7:0]          exp_byte;
    state_t              ok_state;
    logic                resp_fail;

    always_comb begin
        exp_byte = RSP_ACK;
        ok_state = S_W_BAT;
        case (state_q)
            S_W_ACK1: begin exp_byte = RSP_ACK; ok_state = S_W_BAT;  end
            S_W_BAT:  begin exp_byte = RSP_BAT; ok_state = S_W_ID;   end
            S_W_ID:   begin exp_byte = RSP_ID;  ok_state = S_TX_EN;  end
            S_W_ACK2: begin exp_byte = RSP_ACK; ok_state = S_STREAM; end
            default:  ;
        endcase
    end

    // Next-state and next-output logic.
    always_comb begin
        // NOTE: every value written here gets a default first, so no path
        // leaves a signal unassigned and no latch can be inferred.
        state_d      = state_q;
        resp_timer_d = '0;
        retry_d      = retry_q;
        idx_d        = idx_q;
        gap_d        = gap_q;
        byte1_d      = byte1_q;
        byte2_d      = byte2_q;
        tx_data_d    = o_tx_data;
        tx_start_d   = 1'b0;
        sig1_d       = o_signal1;
        sig2_d       = o_signal2;
        sig3_d       = o_signal3;
        pkt_valid_d  = 1'b0;
        resp_fail    = 1'b0;

        case (state_q)
            S_TX_RST: begin
                if (i_tx_ready) begin
                    tx_start_d = 1'b1;
                    tx_data_d  = CMD_RESET;
                    state_d    = S_W_ACK1;
                end
            end

            S_TX_EN: begin
                if (i_tx_ready) begin
                    tx_start_d = 1'b1;
                    tx_data_d  = CMD_ENABLE;
                    state_d    = S_W_ACK2;
                end
            end

            S_W_ACK1, S_W_BAT, S_W_ID, S_W_ACK2: begin
                resp_timer_d = resp_timer_q + 1'b1;
                // A byte arriving on the timeout cycle is judged on its value.
                if (i_rx_valid) begin
                    if (i_rx_data == exp_byte) begin
                        state_d      = ok_state;
                        resp_timer_d = '0;
                    end else begin
                        resp_fail = 1'b1;
                    end
                end else if (resp_timer_q == RESP_LAST) begin
                    resp_fail = 1'b1;
                end

                if (resp_fail) begin
                    resp_timer_d = '0;
                    retry_d      = retry_q + 1'b1;
                    state_d      = (retry_q == RETRY_LAST) ? S_FAIL : S_TX_RST;
                end
            end

            S_STREAM: begin
                if (i_rx_valid) begin
                    // An arriving byte always beats a gap expiry in the same cycle.
                    gap_d = '0;
                    case (idx_q)
                        2'd0: begin
                            // Bit 3 of byte 1 is always set; anything else
                            // is a stray byte from a lost packet.
                            if (i_rx_data[3]) begin
                                byte1_d = i_rx_data;
                                idx_d   = 2'd1;
                            end
                        end
                        2'd1: begin
                            byte2_d = i_rx_data;
                            idx_d   = 2'd2;
                        end
                        default: begin
                            sig1_d      = byte1_q;
                            sig2_d      = byte2_q;
                            sig3_d      = i_rx_data;
                            pkt_valid_d = 1'b1;
                            idx_d       = 2'd0;
                        end
                    endcase
                end else if (idx_q != 2'd0) begin
                    if (gap_q == GAP_LAST) begin
                        idx_d   = 2'd0;
                        gap_d   = '0;
                        byte1_d = '0;
                        byte2_d = '0;
                    end else begin
                        gap_d = gap_q + 1'b1;
                    end
                end
            end

            default: ;  // S_FAIL: everything ignored until reset
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q        <= S_TX_RST;
            resp_timer_q   <= '0;
            retry_q        <= '0;
            idx_q          <= 2'd0;
            gap_q          <= '0;
            byte1_q        <= '0;
            byte2_q        <= '0;
            o_tx_data      <= '0;
            o_tx_start     <= 1'b0;
            o_signal1      <= '0;
            o_signal2      <= '0;
            o_signal3      <= '0;
            o_packet_valid <= 1'b0;
            o_streaming    <= 1'b0;
            o_init_error   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values, independent of statement order.
            state_q        <= state_d;
            resp_timer_q   <= resp_timer_d;
            retry_q        <= retry_d;
            idx_q          <= idx_d;
            gap_q          <= gap_d;
            byte1_q        <= byte1_d;
            byte2_q        <= byte2_d;
            o_tx_data      <= tx_data_d;
            o_tx_start     <= tx_start_d;
            o_signal1      <= sig1_d;
            o_signal2      <= sig2_d;
            o_signal3      <= sig3_d;
            o_packet_valid <= pkt_valid_d;
            o_streaming    <= (state_d == S_STREAM);
            o_init_error   <= (state_d == S_FAIL);
        end
    end

endmodule

// File: tb/tb_ps2_mouse_ctrl.sv
// -----------------------------------------------------------------------------
// tb_ps2_mouse_ctrl
//
// Self-checking bench for ps2_mouse_ctrl. Init handshakes are driven by hand;
// stream traffic comes from a table of {byte, idle-after, expected packet}
// rows. Expected packets are queued when their third byte is driven and
// compared when o_packet_valid appears.
// -----------------------------------------------------------------------------
module tb_ps2_mouse_ctrl;

    localparam int RESP_TIMEOUT = 1000;
    localparam int PKT_GAP      = 100;
    localparam int MAX_RETRY    = 3;

    logic       i_clk = 1'b0;
    logic       i_reset = 1'b0;
    logic [7:0] i_rx_data = 8'h00;
    logic       i_rx_valid = 1'b0;
    logic       i_tx_ready = 1'b0;
    logic [7:0] o_tx_data;
    logic       o_tx_start;
    logic [7:0] o_signal1, o_signal2, o_signal3;
    logic       o_packet_valid;
    logic       o_streaming;
    logic       o_init_error;

    always #5 i_clk = ~i_clk;

    ps2_mouse_ctrl #(
        .RESP_TIMEOUT(RESP_TIMEOUT),
        .PKT_GAP     (PKT_GAP),
        .MAX_RETRY   (MAX_RETRY)
    ) dut (
        .i_clk         (i_clk),
        .i_reset       (i_reset),
        .i_rx_data     (i_rx_data),
        .i_rx_valid    (i_rx_valid),
        .i_tx_ready    (i_tx_ready),
        .o_tx_data     (o_tx_data),
        .o_tx_start    (o_tx_start),
        .o_signal1     (o_signal1),
        .o_signal2     (o_signal2),
        .o_signal3     (o_signal3),
        .o_packet_valid(o_packet_valid),
        .o_streaming   (o_streaming),
        .o_init_error  (o_init_error)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] actual,
                         input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    // ---------------- scoreboard / monitors ----------------
    logic [23:0] exp_q[$];
    int          tx_count  = 0;
    int          pkt_count = 0;
    logic        prev_pv   = 1'b0;
    logic        prev_tx   = 1'b0;

    always @(negedge i_clk) begin
        if (o_packet_valid) begin
            pkt_count++;
            check("packet_valid_one_cycle", {31'd0, prev_pv}, 32'd0);
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_packet: got 0x%06h expected no strobe",
                         {o_signal1, o_signal2, o_signal3});
            end else begin
                logic [23:0] exp_pkt;
                exp_pkt = exp_q.pop_front();
                check("packet_bytes", {8'd0, o_signal1, o_signal2, o_signal3},
                      {8'd0, exp_pkt});
            end
        end
        prev_pv = o_packet_valid;

        if (o_tx_start) begin
            tx_count++;
            check("tx_start_one_cycle", {31'd0, prev_tx}, 32'd0);
        end
        prev_tx = o_tx_start;
    end

    // ---------------- drive helpers ----------------
    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic send(input logic [7:0] b);
        i_rx_data  = b;
        i_rx_valid = 1'b1;
        tick();
        i_rx_valid = 1'b0;
    endtask

    task automatic do_reset();
        i_reset    = 1'b0;
        i_rx_valid = 1'b0;
        i_rx_data  = 8'h00;
        idle(3);
        i_reset = 1'b1;
        tick();
    endtask

    // Wait (bounded) for a command strobe; report cycles waited.
    task automatic expect_tx(input string name, input logic [7:0] exp,
                             input int budget, output int waited);
        waited = -1;
        for (int c = 0; c < budget; c++) begin
            @(negedge i_clk);
            if (o_tx_start) begin
                check(name, {24'd0, o_tx_data}, {24'd0, exp});
                waited = c;
                break;
            end
        end
        if (waited < 0) begin
            checks++;
            failures++;
            $display("FAIL %s: no tx strobe within %0d cycles, expected 0x%02h",
                     name, budget, exp);
        end
        @(posedge i_clk);
        #1;
    endtask

    // ---------------- stream vector table ----------------
    typedef struct {
        logic [7:0]  data;
        int          idle_after;
        logic        push;
        logic [23:0] pkt;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic [7:0] d, input int i, input logic p,
                       input logic [23:0] k);
        vec_t v;
        v.data       = d;
        v.idle_after = i;
        v.push       = p;
        v.pkt        = k;
        vecs.push_back(v);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        int tx0;

        // Back-to-back packet
        add(8'h09, 0, 1'b0, 24'h0);
        add(8'h10, 0, 1'b0, 24'h0);
        add(8'hF0, 2, 1'b1, 24'h0910F0);
        // Resync: 0x00 lacks bit 3 and is discarded
        add(8'h00, 0, 1'b0, 24'h0);
        add(8'h28, 1, 1'b0, 24'h0);
        add(8'h05, 0, 1'b0, 24'h0);
        add(8'hFB, 3, 1'b1, 24'h2805FB);
        // Gap expiry after byte 2 drops the pair
        add(8'h09, 0, 1'b0, 24'h0);
        add(8'h10, PKT_GAP, 1'b0, 24'h0);
        add(8'h0A, 0, 1'b0, 24'h0);
        add(8'h01, 0, 1'b0, 24'h0);
        add(8'h02, 3, 1'b1, 24'h0A0102);
        // Byte on the expiry cycle is still taken as byte 3
        add(8'h09, 0, 1'b0, 24'h0);
        add(8'h10, PKT_GAP - 1, 1'b0, 24'h0);
        add(8'h0C, 3, 1'b1, 24'h09100C);
        // Gap expiry after byte 1
        add(8'h08, PKT_GAP, 1'b0, 24'h0);
        add(8'h1F, 0, 1'b0, 24'h0);
        add(8'h7F, 0, 1'b0, 24'h0);
        add(8'h80, 3, 1'b1, 24'h1F7F80);

        // ---------------- reset state ----------------
        idle(3);
        check("reset_signals", {8'd0, o_signal1, o_signal2, o_signal3}, 32'd0);
        check("reset_tx", {23'd0, o_tx_start, o_tx_data}, 32'd0);
        check("reset_flags", {29'd0, o_packet_valid, o_streaming, o_init_error}, 32'd0);

        // TX_RST waits for i_tx_ready
        i_reset = 1'b1;
        idle(5);
        check("tx_waits_ready", tx_count, 0);

        // ---------------- init happy path ----------------
        tx0 = tx_count;
        i_tx_ready = 1'b1;
        expect_tx("tx_reset_cmd", 8'hFF, 20, w);
        check("tx_data_hold", {24'd0, o_tx_data}, 32'h0000_00FF);
        send(8'hFA);
        send(8'hAA);
        send(8'h00);
        expect_tx("tx_enable_cmd", 8'hF4, 20, w);
        i_rx_data  = 8'hFA;
        i_rx_valid = 1'b1;
        @(negedge i_clk);
        check("streaming_before_ack", {31'd0, o_streaming}, 32'd0);
        tick();
        i_rx_valid = 1'b0;
        check("streaming_after_ack", {31'd0, o_streaming}, 32'd1);
        check("init_error_clear", {31'd0, o_init_error}, 32'd0);
        check("init_tx_count", tx_count - tx0, 32'd2);

        // ---------------- stream table ----------------
        foreach (vecs[i]) begin
            if (vecs[i].push) exp_q.push_back(vecs[i].pkt);
            send(vecs[i].data);
            idle(vecs[i].idle_after);
        end
        check("packet_count", pkt_count, 32'd5);
        check("stream_no_tx", tx_count - tx0, 32'd2);

        // Partial packet must not disturb the held outputs
        send(8'h18);
        send(8'h20);
        idle(5);
        check("hold_after_partial", {8'd0, o_signal1, o_signal2, o_signal3},
              32'h001F_7F80);

        // ---------------- async reset between bytes 2 and 3 ----------------
        #2;
        i_reset = 1'b0;
        #1;
        check("async_rst_signals", {8'd0, o_signal1, o_signal2, o_signal3}, 32'd0);
        check("async_rst_tx", {23'd0, o_tx_start, o_tx_data}, 32'd0);
        check("async_rst_flags",
              {29'd0, o_packet_valid, o_streaming, o_init_error}, 32'd0);
        i_tx_ready = 1'b0;
        tick();
        idle(2);
        tx0 = tx_count;
        i_reset = 1'b1;
        idle(10);
        check("after_rst_waits_ready", tx_count - tx0, 32'd0);
        i_tx_ready = 1'b1;
        expect_tx("after_rst_reset_cmd", 8'hFF, 20, w);

        // ---------------- init failure: 0xFE to every 0xFF ----------------
        tx0 = tx_count;
        do_reset();
        for (int a = 0; a < MAX_RETRY; a++) begin
            expect_tx("nack_retry_cmd", 8'hFF, 20, w);
            send(8'hFE);
        end
        idle(5);
        check("nack_init_error", {31'd0, o_init_error}, 32'd1);
        check("nack_streaming", {31'd0, o_streaming}, 32'd0);
        check("nack_tx_count", tx_count - tx0, MAX_RETRY);
        send(8'hFA);
        idle(50);
        check("fail_sticky", {31'd0, o_init_error}, 32'd1);
        check("fail_no_more_tx", tx_count - tx0, MAX_RETRY);

        // ---------------- init failure: silence ----------------
        tx0 = tx_count;
        do_reset();
        expect_tx("silent_first_cmd", 8'hFF, 20, w);
        for (int a = 1; a < MAX_RETRY; a++) begin
            expect_tx("silent_retry_cmd", 8'hFF, RESP_TIMEOUT + 50, w);
            check("silent_retry_interval",
                  {31'd0, (w >= RESP_TIMEOUT - 2) && (w <= RESP_TIMEOUT + 2)}, 32'd1);
        end
        idle(RESP_TIMEOUT + 50);
        check("silent_init_error", {31'd0, o_init_error}, 32'd1);
        check("silent_streaming", {31'd0, o_streaming}, 32'd0);
        check("silent_tx_count", tx_count - tx0, MAX_RETRY);

        check("scoreboard_drained", exp_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
